pet2001screen_uart: RTL and testbench

//  Snoops CPU writes to PET video RAM and sends each character written to the screen out as 8N1 serial ASCII.

---
 rtl/pet2001screen_uart_pkg.sv | 28 ++
 rtl/pet2001screen_uart_if.sv | 9 +
 rtl/uart_tx_core.sv | 58 +++++
 rtl/pet2001screen_uart.sv | 155 +++++++++++++++
 tb/tb_pet2001screen_uart.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pet2001screen_uart_pkg.sv
// rtl/pet2001screen_uart_pkg.sv - shared constants, front-end states and screen-code translation
package pet2001screen_uart_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] GFX_SUB     = 8'h23;
    localparam int         SCREEN_ROWS = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_CR = 2'd1,
        PUSH_LF = 2'd2,
        PUSH_CH = 2'd3
    } fe_state_t;

    // Reverse-field bit is dropped; graphics codes collapse to a single substitute.
    function automatic logic [7:0] screen_to_ascii(input logic [7:0] code);
        logic [7:0] c;
        c = {1'b0, code[6:0]};
        if (c < 8'h20)
            return c + 8'h40;
        else if (c < 8'h40)
            return c;
        else
            return GFX_SUB;
    endfunction

endpackage

// File: rtl/pet2001screen_uart_if.sv
// rtl/pet2001screen_uart_if.sv - video RAM write snoop bus
interface pet2001screen_uart_if;
    logic       vid_we;
    logic [9:0] vid_addr;
    logic [7:0] vid_data;

    modport master (output vid_we, vid_addr, vid_data);
    modport slave  (input  vid_we, vid_addr, vid_data);
endinterface

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 transmitter: bit timer and shifter
module uart_tx_core #(
    parameter int CLK_DIVIDER = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       busy,
    output logic       serial_out
);

    localparam int DW = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;

    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          bit_end;
    logic          last;

    assign bit_end = (div_cnt == DW'(CLK_DIVIDER - 1));
    assign last    = busy && bit_end && (bit_cnt == 4'd9);
    // Accepting a byte in the final stop-bit cycle makes frames abut with no idle gap.
    assign ready   = !busy || last;

    // Frame sequencer: start bit on load, then data LSB first, then stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            serial_out <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= 9'h1FF;
        end else if (start && ready) begin
            shreg      <= {1'b1, data};
            serial_out <= 1'b0;
            busy       <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
        end else if (busy) begin
            if (bit_end) begin
                div_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    busy       <= 1'b0;
                    serial_out <= 1'b1;
                end else begin
                    bit_cnt    <= bit_cnt + 4'd1;
                    serial_out <= shreg[0];
                    shreg      <= {1'b1, shreg[8:1]};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pet2001screen_uart.sv
// rtl/pet2001screen_uart.sv - screen-write snooper to serial ASCII transcript (option: PETTX_FLOW_CTRL_EN)
module pet2001screen_uart
    import pet2001screen_uart_pkg::*;
#(
    parameter int CLK_DIVIDER = 5208,
    parameter int FIFO_DEPTH  = 16,
    parameter int COLS        = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    pet2001screen_uart_if.slave    vid,
    input  logic                   enable,
    input  logic                   ovf_clr,
`ifdef PETTX_FLOW_CTRL_EN
    input  logic                   cts_n,
`endif
    output logic                   serial_out,
    output logic                   tx_busy,
    output logic                   fifo_empty,
    output logic                   overflow
);

    localparam int               AW        = $clog2(FIFO_DEPTH);
    localparam logic [10:0]      NUM_CELLS = 11'(COLS * SCREEN_ROWS);
    localparam logic [AW:0]      DEPTH_V   = (AW + 1)'(FIFO_DEPTH);

    fe_state_t    state, state_n;
    logic [4:0]   last_row;
    logic [7:0]   char_q;
    logic [4:0]   row;
    logic         new_row;
    logic [AW:0]  need;
    logic [AW:0]  free_cnt;
    logic         snoop, accept, drop;
    logic         push;
    logic [7:0]   push_data;
    logic         pop;
    logic         tx_ready;
    logic         tx_allow;

    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]  count;

    assign row      = 5'(vid.vid_addr / 10'(COLS));
    assign new_row  = (row != last_row);
    assign need     = new_row ? (AW + 1)'(3) : (AW + 1)'(1);
    assign free_cnt = DEPTH_V - count;
    // Off-screen writes (e.g. beyond the 25th row) are not characters and never count as drops.
    assign snoop    = vid.vid_we && enable && ({1'b0, vid.vid_addr} < NUM_CELLS);
    // Room for the whole CR/LF/char group is reserved up front so pushes can never hit a full FIFO.
    assign accept   = snoop && (state == IDLE) && (free_cnt >= need);
    assign drop     = snoop && !accept;

`ifdef PETTX_FLOW_CTRL_EN
    assign tx_allow = !cts_n;
`else
    assign tx_allow = 1'b1;
`endif

    assign fifo_empty = (count == '0);
    assign pop        = tx_ready && !fifo_empty && tx_allow;

    // Front-end next state: each push state emits exactly one byte.
    always_comb begin
        state_n   = state;
        push      = 1'b0;
        push_data = 8'h00;
        case (state)
            IDLE: begin
                if (accept)
                    state_n = new_row ? PUSH_CR : PUSH_CH;
            end
            PUSH_CR: begin
                push      = 1'b1;
                push_data = ASCII_CR;
                state_n   = PUSH_LF;
            end
            PUSH_LF: begin
                push      = 1'b1;
                push_data = ASCII_LF;
                state_n   = PUSH_CH;
            end
            PUSH_CH: begin
                push      = 1'b1;
                push_data = char_q;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Front-end state, latched character and row tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            char_q   <= 8'h00;
            last_row <= 5'h1F;
        end else begin
            state <= state_n;
            if (accept) begin
                char_q   <= screen_to_ascii(vid.vid_data);
                last_row <= row;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    uart_tx_core #(
        .CLK_DIVIDER (CLK_DIVIDER)
    ) u_tx (
        .clk        (clk),
        .reset      (reset),
        .data       (mem[rd_ptr]),
        .start      (pop),
        .ready      (tx_ready),
        .busy       (tx_busy),
        .serial_out (serial_out)
    );

endmodule

// File: tb/tb_pet2001screen_uart.sv
// tb/tb_pet2001screen_uart.sv - directed self-checking bench for pet2001screen_uart
module tb_pet2001screen_uart;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic ovf_clr = 1'b0;
`ifdef PETTX_FLOW_CTRL_EN
    logic cts_n = 1'b0;
`endif
    logic serial_out, tx_busy, fifo_empty, overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pet2001screen_uart_if vif ();

    pet2001screen_uart #(
        .CLK_DIVIDER (DIV),
        .FIFO_DEPTH  (16),
        .COLS        (40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vid        (vif),
        .enable     (enable),
        .ovf_clr    (ovf_clr),
`ifdef PETTX_FLOW_CTRL_EN
        .cts_n      (cts_n),
`endif
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line decoder: samples mid-bit on the falling edge and records byte and start cycle.
    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         rx_ferr = 0;
    bit         rx_active = 1'b0;
    int         rx_ph = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (serial_out === 1'b0) begin
                rx_active = 1'b1;
                rx_ph = 0;
                rx_t.push_back(cyc);
            end
        end else begin
            rx_ph++;
            if (rx_ph >= DIV + DIV/2 && rx_ph <= 8*DIV + DIV/2 && (rx_ph % DIV) == DIV/2)
                rx_sh = {serial_out, rx_sh[7:1]};
            if (rx_ph == 9*DIV + DIV/2 && serial_out !== 1'b1)
                rx_ferr++;
            if (rx_ph == 10*DIV - 1) begin
                rx_active = 1'b0;
                rx_q.push_back(rx_sh);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        vif.vid_we = 1'b0;
        tick(3);
        reset = 1'b0;
        rx_q.delete();
        rx_t.delete();
        rx_ferr = 0;
        tick(1);
    endtask

    task automatic vwrite(input logic [9:0] addr, input logic [7:0] data);
        vif.vid_addr = addr;
        vif.vid_data = data;
        vif.vid_we   = 1'b1;
        tick(1);
        vif.vid_we   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        tick(1);
    endtask

    task automatic test_reset;
        apply_reset();
        n_assert++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial_out got %b want 1", serial_out); end
        n_assert++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_empty got %b want 1", fifo_empty); end
        n_assert++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_new_row;
        logic [7:0] exp [3];
        exp = '{8'h0D, 8'h0A, 8'h41};
        apply_reset();
        vwrite(10'd0, 8'h01);
        wait_rx(3, 3*10*DIV + 100);
        n_assert++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL new_row_count got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) begin
                n_assert++;
                if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL new_row_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
            end
        end
        if (rx_t.size() >= 3) begin
            n_assert++; if (rx_t[1] - rx_t[0] !== 10*DIV) begin n_fail++; $display("FAIL b2b_gap0 got %0d want %0d", rx_t[1] - rx_t[0], 10*DIV); end
            n_assert++; if (rx_t[2] - rx_t[1] !== 10*DIV) begin n_fail++; $display("FAIL b2b_gap1 got %0d want %0d", rx_t[2] - rx_t[1], 10*DIV); end
        end
        tick(5);
        n_assert++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL new_row_idle_busy got %b want 0", tx_busy); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL new_row_idle_empty got %b want 1", fifo_empty); end
        n_assert++; if (rx_ferr !== 0)       begin n_fail++; $display("FAIL new_row_framing got %0d want 0", rx_ferr); end
    endtask

    task automatic test_rows;
        logic [7:0] exp [7];
        exp = '{8'h0D, 8'h0A, 8'h41, 8'h42, 8'h0D, 8'h0A, 8'h30};
        apply_reset();
        vwrite(10'd0, 8'h01);  tick(3);
        vwrite(10'd1, 8'h02);  tick(3);
        vwrite(10'd40, 8'h30); tick(3);
        wait_rx(7, 7*10*DIV + 100);
        n_assert++; if (rx_q.size() !== 7) begin n_fail++; $display("FAIL rows_count got %0d want 7", rx_q.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < rx_q.size()) begin
                n_assert++;
                if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL rows_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
            end
        end
    endtask

    task automatic test_translate;
        logic [7:0] exp [6];
        logic [7:0] din [4];
        exp = '{8'h0D, 8'h0A, 8'h41, 8'h20, 8'h23, 8'h23};
        din = '{8'h81, 8'h20, 8'h5F, 8'hE0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            vwrite(10'd5, din[i]);
            tick(3);
        end
        vwrite(10'd1000, 8'h01);
        tick(3);
        enable = 1'b0;
        vwrite(10'd5, 8'h01);
        tick(1);
        enable = 1'b1;
        wait_rx(6, 6*10*DIV + 100);
        tick(10*DIV + 20);
        n_assert++; if (rx_q.size() !== 6) begin n_fail++; $display("FAIL xlate_count got %0d want 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) begin
                n_assert++;
                if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL xlate_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
            end
        end
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL offscreen_overflow got %b want 0", overflow); end
    endtask

    task automatic test_overflow;
        apply_reset();
        vwrite(10'd0, 8'h01);
        wait_rx(3, 3*10*DIV + 100);
        tick(5);
        rx_q.delete();
        rx_t.delete();
        for (int k = 0; k < 20; k++) begin
            vwrite(10'd0, 8'(k + 1));
            tick(1);
        end
        n_assert++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
        wait_rx(17, 17*10*DIV + 100);
        tick(10*DIV + 20);
        n_assert++; if (rx_q.size() !== 17) begin n_fail++; $display("FAIL ovf_sent_count got %0d want 17", rx_q.size()); end
        for (int i = 0; i < 17; i++) begin
            if (i < rx_q.size()) begin
                n_assert++;
                if (rx_q[i] !== 8'(8'h41 + i)) begin n_fail++; $display("FAIL ovf_byte%0d got %h want %h", i, rx_q[i], 8'(8'h41 + i)); end
            end
        end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got %b want 1", fifo_empty); end
    endtask

    task automatic test_busy_drop_and_reset;
        logic [7:0] exp [3];
        exp = '{8'h0D, 8'h0A, 8'h41};
        apply_reset();
        vif.vid_addr = 10'd0;
        vif.vid_data = 8'h01;
        vif.vid_we   = 1'b1;
        tick(1);
        vif.vid_we   = 1'b0;
        tick(1);
        vwrite(10'd1, 8'h02);
        tick(1);
        n_assert++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL pushlf_drop_ovf got %b want 1", overflow); end
        wait_rx(3, 3*10*DIV + 100);
        tick(10*DIV + 20);
        n_assert++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL pushlf_count got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) begin
                n_assert++;
                if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL pushlf_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
            end
        end
        vwrite(10'd1, 8'h03);
        tick(1);
        vwrite(10'd1, 8'h04);
        n_assert++; if (serial_out !== 1'b0) begin n_fail++; $display("FAIL start_bit got %b want 0", serial_out); end
        tick(1);
        n_assert++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL pre_reset_empty got %b want 0", fifo_empty); end
        #2;
        reset = 1'b1;
        #1;
        n_assert++; if (serial_out !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_line got %b want 1", serial_out); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_empty got %b want 1", fifo_empty); end
        n_assert++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL midframe_reset_busy got %b want 0", tx_busy); end
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

`ifdef PETTX_FLOW_CTRL_EN
    task automatic test_flow_ctrl;
        int lows;
        int k;
        logic [7:0] exp [3];
        exp = '{8'h0D, 8'h0A, 8'h41};
        apply_reset();
        cts_n = 1'b1;
        vwrite(10'd0, 8'h01);
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (serial_out !== 1'b1) lows++;
        end
        tick(1);
        n_assert++; if (lows !== 0)          begin n_fail++; $display("FAIL cts_hold_line got %0d low cycles want 0", lows); end
        n_assert++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL cts_hold_fifo got %b want 0", fifo_empty); end
        cts_n = 1'b0;
        k = 0;
        while (serial_out !== 1'b0 && k < 4) begin
            @(negedge clk);
            k++;
        end
        n_assert++; if (k > 2) begin n_fail++; $display("FAIL cts_start_latency got %0d want <=2", k); end
        wait_rx(3, 3*10*DIV + 100);
        n_assert++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL cts_count got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) begin
                n_assert++;
                if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL cts_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
            end
        end
    endtask
`endif

    initial begin
        vif.vid_we   = 1'b0;
        vif.vid_addr = 10'd0;
        vif.vid_data = 8'h00;
        test_reset();
        test_new_row();
        test_rows();
        test_translate();
        test_overflow();
        test_busy_drop_and_reset();
`ifdef PETTX_FLOW_CTRL_EN
        test_flow_ctrl();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
